// File: rtl/pong_game_ctrl_if.sv
// Pong game controller bus: per-frame controls in, positions and game status out.
interface pong_game_ctrl_if;
    logic       frame_tick;
    logic       btn_left;
    logic       btn_right;
    logic       serve;
    logic [9:0] paddle_x;
    logic [9:0] ball_x;
    logic [8:0] ball_y;
    logic [7:0] score;
    logic [1:0] misses;
    logic [1:0] state;
    logic       game_over;

    // Master drives the controls and observes the game (testbench or frame logic).
    modport master (
        output frame_tick, btn_left, btn_right, serve,
        input  paddle_x, ball_x, ball_y, score, misses, state, game_over
    );

    // Slave is the game controller itself.
    modport slave (
        input  frame_tick, btn_left, btn_right, serve,
        output paddle_x, ball_x, ball_y, score, misses, state, game_over
    );
endinterface

// File: rtl/pong_game_ctrl.sv
// Per-frame Pong sequencer: paddle, ball motion, collisions, score/miss and game FSM.
module pong_game_ctrl #(
    parameter int unsigned SCREEN_W    = 640,
    parameter int unsigned SCREEN_H    = 480,
    parameter int unsigned PADDLE_W    = 64,
    parameter int unsigned PADDLE_Y    = 448,
    parameter int unsigned BALL_SIZE   = 8,
    parameter int unsigned PADDLE_STEP = 4,
    parameter int unsigned BALL_STEP   = 2,
    parameter int unsigned MISS_FRAMES = 60,
    parameter int unsigned MAX_MISSES  = 3
) (
    input logic             clk,
    input logic             reset,
    pong_game_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StPlay = 2'd1,
        StMiss = 2'd2,
        StOver = 2'd3
    } state_e;

    localparam int unsigned CntW = $clog2(MISS_FRAMES + 1);

    // X-axis quantities carry one extra bit so comparisons never wrap.
    localparam logic [10:0] PxMax   = 11'(SCREEN_W - PADDLE_W);
    localparam logic [10:0] PStep   = 11'(PADDLE_STEP);
    localparam logic [10:0] BxStep  = 11'(BALL_STEP);
    localparam logic [10:0] BxMax   = 11'(SCREEN_W - BALL_SIZE);
    localparam logic [10:0] BallW   = 11'(BALL_SIZE);
    localparam logic [10:0] PadW    = 11'(PADDLE_W);
    localparam logic [10:0] ParkOfs = 11'((PADDLE_W - BALL_SIZE) / 2);
    localparam logic [9:0]  PxReset = 10'((SCREEN_W - PADDLE_W) / 2);
    localparam logic [9:0]  BxReset = 10'((SCREEN_W - PADDLE_W) / 2 + (PADDLE_W - BALL_SIZE) / 2);

    // Y-axis quantities, likewise one bit wider than ball_y.
    localparam logic [9:0] ByStep = 10'(BALL_STEP);
    localparam logic [9:0] ByPark = 10'(PADDLE_Y - BALL_SIZE);
    localparam logic [9:0] ByMax  = 10'(SCREEN_H - BALL_SIZE);
    localparam logic [9:0] PadY   = 10'(PADDLE_Y);
    localparam logic [9:0] BallH  = 10'(BALL_SIZE);

    logic [9:0]      paddle_x_q, paddle_x_d, paddle_mv, park_x, park_cur;
    logic [9:0]      ball_x_q, ball_x_d;
    logic [8:0]      ball_y_q, ball_y_d;
    logic            dx_left_q, dx_left_d;
    logic            dy_down_q, dy_down_d;
    logic [7:0]      score_q, score_d;
    logic [1:0]      misses_q, misses_d;
    logic [CntW-1:0] miss_cnt_q, miss_cnt_d;
    state_e          state_q, state_d;
    logic            game_over_q, game_over_d;

    logic [10:0] px_w, bx_w;
    logic [9:0]  by_w;
    logic        paddle_hit;

    assign px_w = {1'b0, paddle_x_q};
    assign bx_w = {1'b0, ball_x_q};
    assign by_w = {1'b0, ball_y_q};

    // Ball bottom reaches the paddle line this step and overlaps the paddle horizontally.
    assign paddle_hit = (by_w + BallH <= PadY) && (by_w + BallH + ByStep >= PadY) &&
                        (bx_w + BallW > px_w) && (bx_w < px_w + PadW);

    assign park_x   = 10'({1'b0, paddle_mv} + ParkOfs);
    assign park_cur = 10'(px_w + ParkOfs);

    // Candidate paddle position from the buttons, saturating at both screen edges.
    always_comb begin
        paddle_mv = paddle_x_q;
        if (bus.btn_left && !bus.btn_right) begin
            paddle_mv = (px_w <= PStep) ? '0 : 10'(px_w - PStep);
        end else if (bus.btn_right && !bus.btn_left) begin
            paddle_mv = (px_w + PStep >= PxMax) ? 10'(PxMax) : 10'(px_w + PStep);
        end
    end

    // Next-state and datapath updates, applied only on frame ticks.
    always_comb begin
        state_d    = state_q;
        paddle_x_d = paddle_x_q;
        ball_x_d   = ball_x_q;
        ball_y_d   = ball_y_q;
        dx_left_d  = dx_left_q;
        dy_down_d  = dy_down_q;
        score_d    = score_q;
        misses_d   = misses_q;
        miss_cnt_d = miss_cnt_q;
        if (bus.frame_tick) begin
            unique case (state_q)
                StIdle: begin
                    paddle_x_d = paddle_mv;
                    if (bus.serve) begin
                        // Launch from the current parked position.
                        state_d   = StPlay;
                        dx_left_d = 1'b0;
                        dy_down_d = 1'b0;
                    end else begin
                        ball_x_d = park_x;
                        ball_y_d = 9'(ByPark);
                    end
                end
                StPlay: begin
                    paddle_x_d = paddle_mv;
                    if (dx_left_q) begin
                        if (bx_w <= BxStep) begin
                            ball_x_d  = '0;
                            dx_left_d = 1'b0;
                        end else begin
                            ball_x_d = 10'(bx_w - BxStep);
                        end
                    end else if (bx_w + BxStep >= BxMax) begin
                        ball_x_d  = 10'(BxMax);
                        dx_left_d = 1'b1;
                    end else begin
                        ball_x_d = 10'(bx_w + BxStep);
                    end
                    if (!dy_down_q) begin
                        if (by_w <= ByStep) begin
                            ball_y_d  = '0;
                            dy_down_d = 1'b1;
                        end else begin
                            ball_y_d = 9'(by_w - ByStep);
                        end
                    end else if (paddle_hit) begin
                        ball_y_d  = 9'(ByPark);
                        dy_down_d = 1'b0;
                        if (score_q != 8'hFF) begin
                            score_d = score_q + 8'd1;
                        end
                    end else if (by_w + ByStep >= ByMax) begin
                        ball_y_d   = 9'(ByMax);
                        misses_d   = misses_q + 2'd1;
                        miss_cnt_d = CntW'(MISS_FRAMES);
                        state_d    = StMiss;
                    end else begin
                        ball_y_d = 9'(by_w + ByStep);
                    end
                end
                StMiss: begin
                    miss_cnt_d = miss_cnt_q - CntW'(1);
                    if (miss_cnt_q <= CntW'(1)) begin
                        if (misses_q == 2'(MAX_MISSES)) begin
                            state_d = StOver;
                        end else begin
                            state_d  = StIdle;
                            ball_x_d = park_cur;
                            ball_y_d = 9'(ByPark);
                        end
                    end
                end
                StOver: begin
                    if (bus.serve) begin
                        state_d  = StIdle;
                        score_d  = '0;
                        misses_d = '0;
                        ball_x_d = park_cur;
                        ball_y_d = 9'(ByPark);
                    end
                end
            endcase
        end
        game_over_d = (state_d == StOver);
    end

    // State registers with synchronous reset that overrides any tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            paddle_x_q  <= PxReset;
            ball_x_q    <= BxReset;
            ball_y_q    <= 9'(ByPark);
            dx_left_q   <= 1'b0;
            dy_down_q   <= 1'b0;
            score_q     <= '0;
            misses_q    <= '0;
            miss_cnt_q  <= '0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            paddle_x_q  <= paddle_x_d;
            ball_x_q    <= ball_x_d;
            ball_y_q    <= ball_y_d;
            dx_left_q   <= dx_left_d;
            dy_down_q   <= dy_down_d;
            score_q     <= score_d;
            misses_q    <= misses_d;
            miss_cnt_q  <= miss_cnt_d;
            game_over_q <= game_over_d;
        end
    end

    assign bus.paddle_x  = paddle_x_q;
    assign bus.ball_x    = ball_x_q;
    assign bus.ball_y    = ball_y_q;
    assign bus.score     = score_q;
    assign bus.misses    = misses_q;
    assign bus.state     = state_q;
    assign bus.game_over = game_over_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: directed game scenarios plus random play against a reference model.
module tb_pong_game_ctrl;

    localparam int SW = 640, SH = 480, PW = 64, PY = 448, BS = 8;
    localparam int PSTEP = 4, BSTEP = 2, MISSF = 60, MAXM = 3;

    logic clk = 1'b0;
    logic reset;
    pong_game_ctrl_if bus ();

    pong_game_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: directions as +1/-1, state as 0..3.
    int m_px, m_bx, m_by, m_dx, m_dy, m_score, m_miss, m_st, m_cnt;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_px = (SW - PW) / 2;
        m_bx = m_px + (PW - BS) / 2;
        m_by = PY - BS;
        m_dx = 1;
        m_dy = -1;
        m_score = 0;
        m_miss = 0;
        m_st = 0;
        m_cnt = 0;
    endtask

    task automatic model_tick(input bit bl, input bit br, input bit sv);
        int npx, nbx, nby;
        bit hit;
        npx = m_px;
        if (bl && !br) npx = (m_px - PSTEP < 0) ? 0 : m_px - PSTEP;
        else if (br && !bl) npx = (m_px + PSTEP > SW - PW) ? SW - PW : m_px + PSTEP;
        case (m_st)
            0: begin
                if (sv) begin
                    m_st = 1;
                    m_dx = 1;
                    m_dy = -1;
                end else begin
                    m_bx = npx + (PW - BS) / 2;
                    m_by = PY - BS;
                end
                m_px = npx;
            end
            1: begin
                if (m_dx < 0 && m_bx <= BSTEP) begin
                    nbx = 0; m_dx = 1;
                end else if (m_dx > 0 && m_bx + BSTEP >= SW - BS) begin
                    nbx = SW - BS; m_dx = -1;
                end else begin
                    nbx = m_bx + BSTEP * m_dx;
                end
                hit = (m_by + BS <= PY) && (m_by + BS + BSTEP >= PY) &&
                      (m_bx + BS > m_px) && (m_bx < m_px + PW);
                if (m_dy < 0) begin
                    if (m_by <= BSTEP) begin
                        nby = 0; m_dy = 1;
                    end else begin
                        nby = m_by - BSTEP;
                    end
                end else if (hit) begin
                    nby = PY - BS;
                    m_dy = -1;
                    m_score = (m_score >= 255) ? 255 : m_score + 1;
                end else if (m_by + BSTEP >= SH - BS) begin
                    nby = SH - BS;
                    m_miss++;
                    m_cnt = MISSF;
                    m_st = 2;
                end else begin
                    nby = m_by + BSTEP;
                end
                m_px = npx;
                m_bx = nbx;
                m_by = nby;
            end
            2: begin
                m_cnt--;
                if (m_cnt == 0) begin
                    if (m_miss == MAXM) m_st = 3;
                    else begin
                        m_st = 0;
                        m_bx = m_px + (PW - BS) / 2;
                        m_by = PY - BS;
                    end
                end
            end
            default: begin
                if (sv) begin
                    m_st = 0;
                    m_score = 0;
                    m_miss = 0;
                    m_bx = m_px + (PW - BS) / 2;
                    m_by = PY - BS;
                end
            end
        endcase
    endtask

    task automatic compare_all();
        check("paddle_x", int'(bus.paddle_x), m_px);
        check("ball_x", int'(bus.ball_x), m_bx);
        check("ball_y", int'(bus.ball_y), m_by);
        check("score", int'(bus.score), m_score);
        check("misses", int'(bus.misses), m_miss);
        check("state", int'(bus.state), m_st);
        check("game_over", int'(bus.game_over), (m_st == 3) ? 1 : 0);
    endtask

    // One clock: drive inputs, let the edge sample them, then compare against the model.
    task automatic cyc(input bit tk, input bit bl, input bit br, input bit sv, input bit rs);
        bus.frame_tick = tk;
        bus.btn_left   = bl;
        bus.btn_right  = br;
        bus.serve      = sv;
        reset          = rs;
        @(posedge clk);
        #1;
        if (rs) model_reset();
        else if (tk) model_tick(bl, br, sv);
        compare_all();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_px"}, int'(bus.paddle_x), 288);
        check({tag, "_bx"}, int'(bus.ball_x), 316);
        check({tag, "_by"}, int'(bus.ball_y), 440);
        check({tag, "_score"}, int'(bus.score), 0);
        check({tag, "_misses"}, int'(bus.misses), 0);
        check({tag, "_state"}, int'(bus.state), 0);
        check({tag, "_gover"}, int'(bus.game_over), 0);
    endtask

    // Tick until the model reaches the target state, bounded by cap ticks.
    task automatic run_to(input int target, input int cap);
        int n;
        n = 0;
        while (m_st != target && n < cap) begin
            cyc(1, 0, 0, 0, 0);
            n++;
        end
        check("reach_state", int'(bus.state), target);
    endtask

    initial begin
        bus.frame_tick = 0;
        bus.btn_left = 0;
        bus.btn_right = 0;
        bus.serve = 0;
        reset = 1;
        model_reset();

        // Reset state.
        cyc(0, 0, 0, 0, 1);
        check_reset_values("rst");

        // Left for 100 ticks: 288/4 = 72 ticks to reach the left edge.
        for (int i = 1; i <= 100; i++) begin
            cyc(1, 1, 0, 0, 0);
            if (i == 71) check("px_t71", int'(bus.paddle_x), 4);
            if (i == 72) check("px_t72", int'(bus.paddle_x), 0);
        end
        check("px_left_sat", int'(bus.paddle_x), 0);
        check("bx_parked", int'(bus.ball_x), 28);
        check("idle_state", int'(bus.state), 0);

        // Both buttons hold still, then right saturates at 576.
        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) cyc(1, 1, 1, 0, 0);
        check("px_both", int'(bus.paddle_x), 288);
        for (int i = 0; i < 200; i++) cyc(1, 0, 1, 0, 0);
        check("px_right_sat", int'(bus.paddle_x), 576);
        check("bx_parked_r", int'(bus.ball_x), 604);

        // Serve, then left for 60 ticks: walls at tick 158/220, paddle hit at 440.
        cyc(0, 0, 0, 0, 1);
        cyc(1, 0, 0, 1, 0);
        check("serve_play", int'(bus.state), 1);
        check("serve_bx", int'(bus.ball_x), 316);
        for (int i = 1; i <= 441; i++) begin
            cyc(1, i <= 60, 0, 0, 0);
            if (i == 60) check("px_48", int'(bus.paddle_x), 48);
            if (i == 158) check("bx_wall_r", int'(bus.ball_x), 632);
            if (i == 159) check("bx_after_r", int'(bus.ball_x), 630);
            if (i == 220) check("by_top", int'(bus.ball_y), 0);
            if (i == 221) check("by_after_top", int'(bus.ball_y), 2);
            if (i == 440) begin
                check("by_hit", int'(bus.ball_y), 440);
                check("score_hit", int'(bus.score), 1);
            end
            if (i == 441) check("by_after_hit", int'(bus.ball_y), 438);
        end
        cyc(0, 1, 1, 1, 0);

        // Three misses with the paddle centred, then game over and restart.
        cyc(0, 0, 0, 0, 1);
        for (int k = 1; k <= 3; k++) begin
            cyc(1, 0, 0, 1, 0);
            run_to(2, 1000);
            check("miss_by", int'(bus.ball_y), 472);
            check("miss_cnt", int'(bus.misses), k);
            cyc(0, 0, 0, 1, 0);
            for (int i = 1; i <= 60; i++) begin
                cyc(1, 1, 0, 0, 0);
                if (i == 59) check("miss_hold", int'(bus.state), 2);
            end
            check("after_miss", int'(bus.state), (k == 3) ? 3 : 0);
        end
        check("game_over", int'(bus.game_over), 1);
        cyc(1, 0, 0, 1, 0);
        check("restart_state", int'(bus.state), 0);
        check("restart_score", int'(bus.score), 0);
        check("restart_misses", int'(bus.misses), 0);

        // Reset wins over a tick mid-PLAY and mid-MISS.
        cyc(0, 0, 0, 0, 1);
        cyc(1, 0, 0, 1, 0);
        for (int i = 0; i < 50; i++) cyc(1, 0, 1, 0, 0);
        cyc(1, 0, 1, 0, 1);
        check_reset_values("rst_play");
        cyc(1, 0, 0, 1, 0);
        run_to(2, 1000);
        for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1);
        check_reset_values("rst_miss");

        // Random play: sparse ticks, random buttons, occasional serve and reset.
        for (int i = 0; i < 20000; i++) begin
            bit tk, bl, br, sv, rs;
            tk = ($urandom_range(0, 3) != 0);
            bl = $urandom_range(0, 1);
            br = $urandom_range(0, 1);
            sv = ($urandom_range(0, 7) == 0);
            rs = ($urandom_range(0, 999) == 0);
            if (tk && sv && m_st == 0) begin
                bl = 0;
                br = 0;
            end
            cyc(tk, bl, br, sv, rs);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Per-frame game sequencer for the VGA Pong design. Once per video frame it updates the player paddle from the two buttons, moves the ball, resolves wall and paddle collisions, counts score and misses, and steps the serve/miss/game-over state machine. Its position outputs feed the pixel-compare logic beside `hvsync_generator`, which draws paddle and ball from `CounterX`/`CounterY`.

## Interface
- SCREEN_W, 640, visible width in pixels
- SCREEN_H, 480, visible height in pixels
- PADDLE_W, 64, paddle width in pixels
- PADDLE_Y, 448, y coordinate of the paddle top edge
- BALL_SIZE, 8, ball edge length in pixels (square ball)
- PADDLE_STEP, 4, paddle movement per frame
- BALL_STEP, 2, ball movement per axis per frame
- MISS_FRAMES, 60, pause length after a miss, in frames
- MAX_MISSES, 3, number of misses that ends the game
- clk  in  1  system clock; the only clock
- reset  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse, once per frame, at the start of vertical blank
- btn_left  in  1  left button, active-high pressed, already synchronized
- btn_right  in  1  right button, active-high pressed, already synchronized
- serve  in  1  level; sampled only on frame_tick
- paddle_x  out  10  paddle left edge
- ball_x  out  10  ball left edge
- ball_y  out  9  ball top edge
- score  out  8  paddle hits, saturating at 255
- misses  out  2  miss count
- state  out  2  IDLE=0, PLAY=1, MISS=2, OVER=3
- game_over  out  1  high while state==OVER

## Operation
- All updates happen only on cycles where frame_tick=1. Every register holds on all other cycles.
- Reset values:
  - paddle_x=(SCREEN_W-PADDLE_W)/2=288
  - ball_x=paddle_x+(PADDLE_W-BALL_SIZE)/2=316
  - ball_y=PADDLE_Y-BALL_SIZE=440
  - dx=right, dy=up
  - score=0, misses=0, state=IDLE, game_over=0
- Paddle update (in IDLE and PLAY only):
  - btn_left only: paddle_x decreases by PADDLE_STEP, saturating at 0.
  - btn_right only: paddle_x increases by PADDLE_STEP, saturating at SCREEN_W-PADDLE_W=576.
  - Both buttons or neither: no change.
- IDLE:
  - The ball is parked on the paddle: ball_x=paddle_x_next+28, ball_y=440.
  - If serve=1 on a tick: go to PLAY with dx=right, dy=up. The paddle still moves on that tick; the ball does not move.
- PLAY: compute every collision from the pre-tick register values; the paddle and ball update in parallel.
  - X axis:
    - Moving left and ball_x<=BALL_STEP: ball_x=0, dx flips to right.
    - Moving right and ball_x+BALL_STEP>=SCREEN_W-BALL_SIZE: ball_x=632, dx flips to left.
    - Otherwise ball_x steps by ±BALL_STEP.
  - Y axis, moving up: if ball_y<=BALL_STEP then ball_y=0 and dy flips to down; otherwise ball_y decreases by BALL_STEP.
  - Y axis, moving down, paddle hit. All of these must hold:
    - ball_y+BALL_SIZE<=PADDLE_Y
    - ball_y+BALL_SIZE+BALL_STEP>=PADDLE_Y
    - ball_x+BALL_SIZE>paddle_x
    - ball_x<paddle_x+PADDLE_W
    - Result: ball_y=440, dy flips to up, score increments (saturating).
  - Y axis, moving down, bottom reached: no paddle hit and ball_y+BALL_STEP>=SCREEN_H-BALL_SIZE. Result: ball_y=472, misses increments, miss counter loads MISS_FRAMES, state goes to MISS.
  - Y axis, moving down, otherwise: ball_y increases by BALL_STEP.
  - The X and Y rules apply together, so a corner hit flips both directions on the same tick.
- MISS:
  - Ball and paddle frozen; the miss counter decrements on each tick.
  - On the tick where the counter reaches 0: go to OVER if misses==MAX_MISSES, otherwise go to IDLE with the ball re-parked.
- OVER:
  - Everything frozen and game_over=1.
  - If serve=1 on a tick: clear score and misses, re-park the ball, go to IDLE.
- All arithmetic uses widths 1 bit wider than the operands, so that comparisons never wrap.

## Timing
- All outputs are registered. Each output changes on the clk edge that samples frame_tick=1, so it is visible 1 cycle after the tick.
- The block needs one tick per frame and performs no multi-cycle computation.
- reset is synchronous and wins over frame_tick: if both are high on the same edge, the reset values load.
- Reset asserted mid-PLAY or mid-MISS returns every output to its reset value on the next edge.
- frame_tick held high for k cycles counts as k ticks. Ticks are not edge-detected.
- serve or a button that is active between ticks is ignored. Only the value present on the tick cycle matters.

## Test plan
- Reset, then hold btn_left for 100 ticks in IDLE: paddle_x reaches 0 after 72 ticks and stays at 0; ball_x=28; state=0.
- Both buttons held for 10 ticks: paddle_x stays 288. Then btn_right for 200 ticks: paddle_x saturates at 576.
- From reset, serve on one tick, then 158 PLAY ticks with no buttons: ball_x=632 with dx=left. At PLAY tick 220: ball_y=0 with dy=down.
- Same run, holding btn_left for the first 60 PLAY ticks (paddle_x=48): at PLAY tick 440, ball_y=440, dy=up, score=1.
- Same run with no buttons (paddle_x=288): the ball passes the paddle line, ball_y=472, state=MISS, misses=1. After 60 more ticks state=IDLE. The third miss gives state=OVER and game_over=1. Serve on a tick then gives state=IDLE, score=0, misses=0.
- Assert reset for 1 cycle during PLAY at the same time as frame_tick: all outputs equal their reset values on the next cycle.
